// File: rtl/vector_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vector_writeback_arbiter
// Description : Gathers results from several vector functional units, each
//               behind a private 2-entry FIFO, and serialises them through a
//               round-robin arbiter onto the single register-file write port.
// Revision    : 1.0 - initial release
// ============================================================================
module vector_writeback_arbiter #(
    parameter int NUMBER_SOURCES   = 4,
    parameter int NUMBER_REGISTERS = 32,
    parameter int REGISTER_LENGTH  = 64,
    localparam int AW              = $clog2(NUMBER_REGISTERS)
) (
    input  logic                                  clock,
    input  logic                                  reset_n,
    input  logic [NUMBER_SOURCES-1:0]             result_valid,
    input  logic [NUMBER_SOURCES*AW-1:0]          result_address,
    input  logic [NUMBER_SOURCES*REGISTER_LENGTH-1:0] result_data,
    output logic [NUMBER_SOURCES-1:0]             result_ready,
    output logic                                  write_enable,
    output logic [AW-1:0]                         write_address,
    output logic [REGISTER_LENGTH-1:0]            write_port,
    output logic                                  busy
);

    localparam int              PTRW     = $clog2(NUMBER_SOURCES);
    localparam logic [PTRW-1:0] LAST_SRC = PTRW'(NUMBER_SOURCES - 1);

    // Per-source FIFO status and head entry, gathered for the arbiter
    logic [NUMBER_SOURCES-1:0]  nonempty;
    logic [NUMBER_SOURCES-1:0]  push;
    logic [NUMBER_SOURCES-1:0]  pop;
    logic [AW-1:0]              head_addr [NUMBER_SOURCES];
    logic [REGISTER_LENGTH-1:0] head_data [NUMBER_SOURCES];

    // Arbiter state and decision
    logic [PTRW-1:0]            rr_ptr_q;
    logic [PTRW-1:0]            rr_ptr_d;
    logic                       grant_valid_d;
    logic [PTRW-1:0]            grant_idx_d;
    logic [PTRW-1:0]            arb_cand;

    // Registered write stage
    logic                       we_q;
    logic [AW-1:0]              waddr_q;
    logic [REGISTER_LENGTH-1:0] wdata_q;

    // ------------------------------------------------------------------
    // Per-source 2-entry FIFOs. Slot 0 is always the head; slot 1 is only
    // occupied when the count is 2. Ready depends only on the registered
    // count so there is no combinational path from the arbiter back out.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUMBER_SOURCES; i++) begin : g_src
        logic [1:0]                 count_q;
        logic [AW-1:0]              addr0_q;
        logic [AW-1:0]              addr1_q;
        logic [REGISTER_LENGTH-1:0] data0_q;
        logic [REGISTER_LENGTH-1:0] data1_q;
        logic [AW-1:0]              in_addr;
        logic [REGISTER_LENGTH-1:0] in_data;

        assign in_addr         = result_address[i*AW +: AW];
        assign in_data         = result_data[i*REGISTER_LENGTH +: REGISTER_LENGTH];
        assign nonempty[i]     = (count_q != 2'd0);
        assign result_ready[i] = (count_q != 2'd2);
        assign push[i]         = result_valid[i] && result_ready[i];
        assign pop[i]          = grant_valid_d && (grant_idx_d == PTRW'(i));
        assign head_addr[i]    = addr0_q;
        assign head_data[i]    = data0_q;

        // FIFO storage and occupancy update on push/pop
        always_ff @(posedge clock) begin
            if (!reset_n) begin
                count_q <= 2'd0;
                addr0_q <= '0;
                addr1_q <= '0;
                data0_q <= '0;
                data1_q <= '0;
            end else begin
                case ({push[i], pop[i]})
                    2'b10: begin
                        count_q <= count_q + 2'd1;
                        if (count_q == 2'd0) begin
                            addr0_q <= in_addr;
                            data0_q <= in_data;
                        end else begin
                            addr1_q <= in_addr;
                            data1_q <= in_data;
                        end
                    end
                    2'b01: begin
                        count_q <= count_q - 2'd1;
                        addr0_q <= addr1_q;
                        data0_q <= data1_q;
                    end
                    2'b11: begin
                        // Only reachable at count 1: head leaves, new entry becomes head
                        addr0_q <= in_addr;
                        data0_q <= in_data;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Round-robin search starting at the pointer, ascending with wrap-around
    always_comb begin
        grant_valid_d = 1'b0;
        grant_idx_d   = '0;
        arb_cand      = '0;
        for (int k = 0; k < NUMBER_SOURCES; k++) begin
            arb_cand = PTRW'((int'(rr_ptr_q) + k) % NUMBER_SOURCES);
            if (!grant_valid_d && nonempty[arb_cand]) begin
                grant_valid_d = 1'b1;
                grant_idx_d   = arb_cand;
            end
        end
    end

    // Pointer moves just past the granted source; holds when nothing granted
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_valid_d) begin
            rr_ptr_d = (grant_idx_d == LAST_SRC) ? '0 : grant_idx_d + PTRW'(1);
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Write stage: strobe for one cycle per grant, address/data hold otherwise
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q <= grant_valid_d;
            if (grant_valid_d) begin
                waddr_q <= head_addr[grant_idx_d];
                wdata_q <= head_data[grant_idx_d];
            end
        end
    end

    assign write_enable  = we_q;
    assign write_address = waddr_q;
    assign write_port    = wdata_q;
    assign busy          = (|nonempty) || we_q;

endmodule
`default_nettype wire

// File: doc/vector_writeback_arbiter.md
Name: vector_writeback_arbiter

Overview:
- Collects results from up to NUMBER_SOURCES vector functional units and serialises them onto the register file's single write port.
- Each source has a private 2-entry buffer with valid/ready handshake.
- A round-robin arbiter pops at most one buffered result per cycle into a registered write stage.
- Output drives write_enable / write_address / write_port of the vector register file directly.

Parameters:
- NUMBER_SOURCES, 4, number of functional-unit result sources (>=2).
- NUMBER_REGISTERS, 32, vector registers addressable; address width AW = $clog2(NUMBER_REGISTERS).
- REGISTER_LENGTH, 64, data width of one register.

Ports:
- clock  input  1  single clock; all state updates on posedge.
- reset_n  input  1  reset, synchronous, active-low; sampled on posedge clock.
- result_valid  input  NUMBER_SOURCES  per-source result present.
- result_address  input  NUMBER_SOURCES*AW  packed destination addresses; source i at [i*AW +: AW].
- result_data  input  NUMBER_SOURCES*REGISTER_LENGTH  packed result data; source i at [i*REGISTER_LENGTH +: REGISTER_LENGTH].
- result_ready  output  NUMBER_SOURCES  per-source buffer can accept.
- write_enable  output  1  register file write strobe.
- write_address  output  AW  register file write address.
- write_port  output  REGISTER_LENGTH  register file write data.
- busy  output  1  any buffer non-empty or write stage valid.

Behaviour:
- Reset, when reset_n is low at a posedge:
  - all buffers empty; write_enable=0, write_address=0, write_port=0.
  - round-robin pointer=0; result_ready all 1 in the following cycle.
  - A transfer offered in the reset cycle is dropped.
  - Reset mid-operation discards every buffered and staged result; no write_enable is produced after the reset edge.
- Per-source buffer:
  - 2-entry FIFO with count 0..2.
  - result_ready[i] = (count_i != 2); depends only on registered state (no comb path from arbiter).
  - Push when result_valid[i] && result_ready[i]. Push to a full buffer is impossible (ready low), even if the same cycle pops it.
  - Simultaneous push and pop at count 1 keeps count 1. Order is FIFO.
- Arbitration (combinational, each cycle):
  - Candidates are sources with count != 0.
  - Search starts at pointer and proceeds ascending with wrap-around; first candidate found is granted and popped.
  - After a grant to source g, pointer <= (g+1) mod NUMBER_SOURCES. With no grant, pointer holds.
  - A result pushed in cycle t is visible to the arbiter no earlier than cycle t+1 (no bypass).
- Write stage (registered):
  - On a grant, the next cycle carries write_enable=1 with the granted entry's address/data.
  - Otherwise write_enable=0; write_address/write_port hold their last values.
  - Latency: accepted at edge t, earliest write_enable in cycle t+2, register file updated at edge t+2.
  - Throughput: 1 write/cycle aggregate.
- Same-address results from different sources are never merged; they are written in grant order and the later write wins.
- busy = (any count != 0) || write_enable.
- No back-pressure input; the register file always accepts writes.

Test Plan:
1. Reset: reset_n=0 for 2 cycles with all result_valid=1 -> write_enable=0, result_ready=4'b1111 after release, busy=0, no writes issued.
2. Single source: source 2 pushes addr=5, data=64'hDEAD_BEEF at edge t -> write_enable=1, write_address=5, write_port=64'hDEAD_BEEF in cycle t+2 only; busy drops at t+3.
3. Round robin: all four sources push one result (addr=i) at the same edge -> writes appear on consecutive cycles with addresses 0,1,2,3. A second round with pointer at 0 again gives the same order.
4. Fairness and wrap: source 3 and source 0 continuously valid, pointer=1 -> grants alternate 3,0,3,0. Neither source is starved for more than 1 cycle.
5. Backpressure: source 1 offers 4 back-to-back results while sources 0, 2, 3 are saturated -> result_ready[1] deasserts once count=2. All 4 results are eventually written in order with none lost or duplicated.
6. Reset mid-stream: 6 results buffered, reset_n=0 for one edge -> next cycle write_enable=0, busy=0, and the dropped results are never written.
